mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the picorv32 native memory interface (valid/ready/addr/wdata/wstrb/rdata).
- Shares the system memory/peripheral bus (RAM, SPI, UART decode) between the CPU (master 0) and a DMA/SD-streaming engine (master 1).
- Sits between the masters and the existing address decoder.
- Sequences one transaction at a time, with a one-cycle bus gap between transactions.

Parameters:
- ARB_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority with master 0 winning.
- TIMEOUT_CYCLES, 1024, slave-response watchdog limit in cycles. Used only with ARB_TIMEOUT_EN.
- TO_RDATA, 32'hDEADBEEF, read data returned on a timed-out transfer.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- m0_valid  in  1  master 0 request.
- m0_addr  in  32  master 0 address.
- m0_wdata  in  32  master 0 write data.
- m0_wstrb  in  4  master 0 byte strobes; 0 = read.
- m0_ready  out  1  master 0 completion pulse.
- m0_rdata  out  32  master 0 read data.
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as master 0, for master 1.
- s_valid  out  1  slave request.
- s_addr  out  32  slave address.
- s_wdata  out  32  slave write data.
- s_wstrb  out  4  slave byte strobes.
- s_ready  in  1  slave completion.
- s_rdata  in  32  slave read data.
- grant  out  1  index of the master currently or last granted.
- busy  out  1  high in the BUSY state.
- timeout_err  out  1  sticky watchdog flag; present only with ARB_TIMEOUT_EN.

Behaviour:
- Reset values: state IDLE; s_valid=0; m0_ready=0; m1_ready=0; grant=0; busy=0; last_grant=1 (so master 0 wins the first tie); timeout_err=0; watchdog counter 0.
- IDLE:
  - No request: stay in IDLE.
  - Any mX_valid: register the grant and go to BUSY.
  - Both requesting, ARB_MODE=0: grant = !last_grant.
  - Both requesting, ARB_MODE=1: grant = 0.
  - Exactly one requesting: grant that master.
- BUSY:
  - s_valid=1. s_addr, s_wdata and s_wstrb are a combinational mux of the granted master's fields.
  - Latency: a request seen in IDLE at cycle N drives s_valid at N+1.
  - When s_ready=1: the granted master's mX_ready=1 in the same cycle and mX_rdata=s_rdata (combinational pass-through). Set last_grant=grant, then go to GAP.
- GAP: exactly one cycle with s_valid=0 and all ready outputs 0, then IDLE. This guarantees the slave sees valid deassert, so back-to-back requests from the same master are never merged.
- Non-granted master: mX_ready is always 0. mX_rdata holds the last value driven to it (registered copy), never the live slave data.
- Granted master drops valid in BUSY before s_ready (protocol violation): abort. s_valid falls next cycle, state goes to GAP, no ready is issued, last_grant is unchanged.
- s_ready asserted outside BUSY: ignored.
- A request arriving during GAP waits; it is arbitrated in the following IDLE cycle.
- Round-robin fairness: with both masters continuously requesting, grants alternate 0,1,0,1 with a period of at least 3 cycles per transaction.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronous); the in-flight transfer is dropped silently.
- grant holds its value through GAP and IDLE until the next arbitration.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - At TIMEOUT_CYCLES-1 without s_ready: force mX_ready=1 with mX_rdata=TO_RDATA (writes are discarded), set timeout_err=1 (sticky until reset), go to GAP.
  - If s_ready arrives on the terminal cycle, the real response takes precedence and timeout_err is not set.
- Undefined: no counter and no timeout_err port; BUSY waits indefinitely for s_ready.

Test Plan:
- Master 0 reads 0x00000100; slave returns 0x12345678 with s_ready two cycles after s_valid → m0_ready pulses for 1 cycle, m0_rdata=0x12345678, s_valid low for exactly 1 cycle after, m1_ready stays 0.
- Both masters issue continuous writes with ARB_MODE=0 → s_addr alternates m0,m1,m0,m1; the first grant goes to master 0; a 1-cycle s_valid gap between every transfer.
- Both masters requesting with ARB_MODE=1 → master 0 gets 4/4 grants while held; master 1 is granted on the cycle after master 0 drops valid.
- Master 1 write of 0xAABBCCDD to 0x40000000 with wstrb=4'b0011 → s_wstrb=4'b0011, s_wdata=0xAABBCCDD, m1_ready on the s_ready cycle.
- Reset asserted in the second BUSY cycle → s_valid=0 and busy=0 asynchronously; after release, a new master 1 request completes normally.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8, slave never ready → m0_ready on BUSY cycle 8 with rdata=0xDEADBEEF, timeout_err=1 and it stays 1 through later good transfers.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter
// Two-master / one-slave arbiter for the picorv32 native memory interface.
// Master 0 is the CPU and master 1 is the DMA/SD streaming engine. The slave
// side feeds the existing RAM/SPI/UART address decoder.
//
// Only one transaction is in flight at a time. After every transaction there
// is one GAP cycle with s_valid low. This lets the slave see valid deassert
// between back-to-back requests from the same master.
//
// Optional feature: define ARB_TIMEOUT_EN to add a slave-response watchdog.
// The watchdog is a counter plus a sticky timeout_err output. When the
// watchdog expires, the granted master gets a completion carrying TO_RDATA.
// ============================================================================
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | no transfer; arbitrate between pending requests
// BUSY  | slave request driven from the granted master; wait for completion
// GAP   | one cycle with s_valid low before arbitrating again
//
module mem_bus_arbiter #(
    parameter int unsigned ARB_MODE       = 0,     // 0: round-robin, 1: master 0 priority
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TO_RDATA       = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic        grant,
    output logic        busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic        timeout_err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_grant;
    logic        r_last_grant;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;

    logic        w_busy;
    logic        w_gnt_valid;
    logic        w_any_req;
    logic        w_next_grant;
    logic        w_slave_done;
    logic        w_timeout;
    logic        w_done;
    logic        w_abort;
    logic [31:0] w_resp_data;

    assign w_busy      = (r_state == ST_BUSY);
    assign w_gnt_valid = r_grant ? m1_valid : m0_valid;
    assign w_any_req   = m0_valid | m1_valid;

    // A completion needs the granted master to still be requesting. If the
    // master has dropped valid, the transfer is an abort, even when the
    // slave happens to answer in the same cycle.
    assign w_slave_done = w_busy & w_gnt_valid & s_ready;
    assign w_abort      = w_busy & ~w_gnt_valid;
    assign w_done       = w_slave_done | w_timeout;

`ifdef ARB_TIMEOUT_EN
    localparam int WDOG_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WDOG_W-1:0] r_wdog;
    logic              r_timeout_err;

    // A real s_ready on the terminal cycle beats the watchdog.
    assign w_timeout   = w_busy & w_gnt_valid & ~s_ready &
                         (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
    assign w_resp_data = w_slave_done ? s_rdata : TO_RDATA;
    assign timeout_err = r_timeout_err;

    // Watchdog: held at zero outside BUSY, so it starts from 0 on every BUSY entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdog <= '0;
        end else if (w_busy) begin
            r_wdog <= r_wdog + WDOG_W'(1);
        end else begin
            r_wdog <= '0;
        end
    end

    // Sticky error flag; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign w_resp_data = s_rdata;
`endif

    // Grant selection for the next IDLE->BUSY transition.
    always_comb begin
        w_next_grant = 1'b0;
        if (m0_valid && m1_valid) begin
            w_next_grant = (ARB_MODE == 0) ? ~r_last_grant : 1'b0;
        end else if (m1_valid) begin
            w_next_grant = 1'b1;
        end
    end

    // Transaction sequencer: IDLE -> BUSY -> GAP -> IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_next_grant;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_done) begin
                        r_last_grant <= r_grant;
                        r_state      <= ST_GAP;
                    end else if (w_abort) begin
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Each master keeps the last data it was handed, so it never sees live slave data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            if (m0_ready) begin
                r_m0_rdata <= w_resp_data;
            end
            if (m1_ready) begin
                r_m1_rdata <= w_resp_data;
            end
        end
    end

    assign s_valid  = w_busy;
    assign s_addr   = r_grant ? m1_addr  : m0_addr;
    assign s_wdata  = r_grant ? m1_wdata : m0_wdata;
    assign s_wstrb  = r_grant ? m1_wstrb : m0_wstrb;

    assign m0_ready = w_done & ~r_grant;
    assign m1_ready = w_done &  r_grant;
    assign m0_rdata = m0_ready ? w_resp_data : r_m0_rdata;
    assign m1_rdata = m1_ready ? w_resp_data : r_m1_rdata;

    assign grant    = r_grant;
    assign busy     = w_busy;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter.
// u_dut_rr runs in round-robin mode and u_dut_fp runs in fixed-priority mode.
// Each instance has its own master drivers and its own slave model.
// Stimulus pushes commands into per-master queues and pushes the expected
// completions, in order, into a per-instance queue. A negedge monitor pops
// an expected completion whenever an instance raises a ready output.
module tb_mem_bus_arbiter;

    localparam int          TO_CYC = 8;
    localparam logic [31:0] RD_OFS = 32'h12345578;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          drop;
    } cmd_t;

    typedef struct {
        logic        m;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        mv  [2][2];
    logic [31:0] ma  [2][2];
    logic [31:0] mw  [2][2];
    logic [3:0]  ms  [2][2];
    logic        mr  [2][2];
    logic [31:0] mrd [2][2];
    logic        sv  [2];
    logic [31:0] sa  [2];
    logic [31:0] sw  [2];
    logic [3:0]  sst [2];
    logic        sr  [2];
    logic [31:0] srd [2];
    logic        gr  [2];
    logic        bz  [2];
`ifdef ARB_TIMEOUT_EN
    logic        toerr [2];
`endif

    int   lat [2];
    logic snever [2];
    int   scnt [2];
    logic svs [2];

    cmd_t        cbuf [4][16];
    int          chead [4];
    int          ctail [4];
    int          vcnt [4];
    logic        done [4];
    exp_t        ebuf [2][32];
    int          ehead [2];
    int          etail [2];
    logic [31:0] lastrd [2][2];
    logic        gapchk [2];

    int chk;
    int errs;

    mem_bus_arbiter #(.ARB_MODE(0), .TIMEOUT_CYCLES(TO_CYC), .TO_RDATA(32'hDEADBEEF)) u_dut_rr (
        .clk(clk), .reset(rst),
        .m0_valid(mv[0][0]), .m0_addr(ma[0][0]), .m0_wdata(mw[0][0]), .m0_wstrb(ms[0][0]),
        .m0_ready(mr[0][0]), .m0_rdata(mrd[0][0]),
        .m1_valid(mv[0][1]), .m1_addr(ma[0][1]), .m1_wdata(mw[0][1]), .m1_wstrb(ms[0][1]),
        .m1_ready(mr[0][1]), .m1_rdata(mrd[0][1]),
        .s_valid(sv[0]), .s_addr(sa[0]), .s_wdata(sw[0]), .s_wstrb(sst[0]),
        .s_ready(sr[0]), .s_rdata(srd[0]),
        .grant(gr[0]), .busy(bz[0])
`ifdef ARB_TIMEOUT_EN
        , .timeout_err(toerr[0])
`endif
    );

    mem_bus_arbiter #(.ARB_MODE(1), .TIMEOUT_CYCLES(TO_CYC), .TO_RDATA(32'hDEADBEEF)) u_dut_fp (
        .clk(clk), .reset(rst),
        .m0_valid(mv[1][0]), .m0_addr(ma[1][0]), .m0_wdata(mw[1][0]), .m0_wstrb(ms[1][0]),
        .m0_ready(mr[1][0]), .m0_rdata(mrd[1][0]),
        .m1_valid(mv[1][1]), .m1_addr(ma[1][1]), .m1_wdata(mw[1][1]), .m1_wstrb(ms[1][1]),
        .m1_ready(mr[1][1]), .m1_rdata(mrd[1][1]),
        .s_valid(sv[1]), .s_addr(sa[1]), .s_wdata(sw[1]), .s_wstrb(sst[1]),
        .s_ready(sr[1]), .s_rdata(srd[1]),
        .grant(gr[1]), .busy(bz[1])
`ifdef ARB_TIMEOUT_EN
        , .timeout_err(toerr[1])
`endif
    );

    // Slave model: answers on BUSY cycle lat+1 with data derived from the address.
    assign sr[0]  = sv[0] && !snever[0] && (scnt[0] == lat[0]);
    assign sr[1]  = sv[1] && !snever[1] && (scnt[1] == lat[1]);
    assign srd[0] = sv[0] ? (sa[0] + RD_OFS) : 32'hBAD0BAD0;
    assign srd[1] = sv[1] ? (sa[1] + RD_OFS) : 32'hBAD0BAD0;

    task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
        end
    endtask

    task automatic req(input int d, input int m, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb, input int drop);
        int k;
        k = d * 2 + m;
        cbuf[k][ctail[k] % 16] = '{addr: addr, wdata: wdata, wstrb: wstrb, drop: drop};
        ctail[k]++;
    endtask

    task automatic expect_done(input int d, input logic m, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb,
                               input int cyc, input logic [31:0] rdata);
        ebuf[d][etail[d] % 32] = '{m: m, addr: addr, wdata: wdata, wstrb: wstrb, rdata: rdata, cyc: cyc};
        etail[d]++;
    endtask

    task automatic xfer(input int d, input int m, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input int cyc, input logic [31:0] rdata);
        req(d, m, addr, wdata, wstrb, 0);
        expect_done(d, m[0], addr, wdata, wstrb, cyc, rdata);
    endtask

    task automatic drain(input int d, input int maxc);
        int n;
        n = 0;
        while ((ehead[d] != etail[d] || chead[2*d] != ctail[2*d] || chead[2*d+1] != ctail[2*d+1])
               && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk++;
        if (n >= maxc) begin
            errs++;
            $display("FAIL drain dut%0d: %0d completions still pending, expected 0", d, etail[d] - ehead[d]);
            ehead[d] = etail[d];
            chead[2*d] = ctail[2*d];
            chead[2*d+1] = ctail[2*d+1];
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: scoreboard compare on every ready pulse, plus the GAP cycle that follows it.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                svs[d] = sv[d];
                if (gapchk[d]) begin
                    gapchk[d] = 1'b0;
                    check("gap_s_valid", d, {31'd0, sv[d]}, 32'd0);
                    check("gap_ready", d, {30'd0, mr[d][1], mr[d][0]}, 32'd0);
                end
                if (mr[d][0] || mr[d][1]) begin
                    if (ehead[d] == etail[d]) begin
                        check("unexpected_ready", d, {30'd0, mr[d][1], mr[d][0]}, 32'd0);
                    end else begin
                        e = ebuf[d][ehead[d] % 32];
                        ehead[d]++;
                        check("ready_sel", d, {30'd0, mr[d][1], mr[d][0]}, e.m ? 32'd2 : 32'd1);
                        check("grant", d, {31'd0, gr[d]}, {31'd0, e.m});
                        check("s_addr", d, sa[d], e.addr);
                        check("s_wdata", d, sw[d], e.wdata);
                        check("s_wstrb", d, {28'd0, sst[d]}, {28'd0, e.wstrb});
                        check("rdata", d, mrd[d][e.m], e.rdata);
                        check("latency", d, scnt[d], e.cyc);
                        check("hold_rdata", d, mrd[d][!e.m], lastrd[d][!e.m]);
                        lastrd[d][e.m] = e.rdata;
                        gapchk[d] = 1'b1;
                    end
                    done[d*2]   = mr[d][0];
                    done[d*2+1] = mr[d][1];
                end
            end
        end
    end

    // Master drivers and slave cycle counters, updated just after each rising edge.
    initial begin : drv
        cmd_t c;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) scnt[d] = svs[d] ? scnt[d] + 1 : 0;
            for (int k = 0; k < 4; k++) begin
                if (done[k]) begin
                    done[k] = 1'b0;
                    chead[k]++;
                    vcnt[k] = 0;
                end else if (chead[k] != ctail[k] && cbuf[k][chead[k] % 16].drop > 0
                             && vcnt[k] >= cbuf[k][chead[k] % 16].drop) begin
                    chead[k]++;
                    vcnt[k] = 0;
                end
                if (chead[k] != ctail[k]) begin
                    c = cbuf[k][chead[k] % 16];
                    mv[k/2][k%2] = 1'b1;
                    ma[k/2][k%2] = c.addr;
                    mw[k/2][k%2] = c.wdata;
                    ms[k/2][k%2] = c.wstrb;
                    vcnt[k]++;
                end else begin
                    mv[k/2][k%2] = 1'b0;
                    ma[k/2][k%2] = 32'd0;
                    mw[k/2][k%2] = 32'd0;
                    ms[k/2][k%2] = 4'd0;
                end
            end
        end
    end

    initial begin : main
        int found;
        chk  = 0;
        errs = 0;
        rst  = 1'b1;
        for (int d = 0; d < 2; d++) begin
            lat[d] = 1; snever[d] = 1'b0; scnt[d] = 0; svs[d] = 1'b0;
            ehead[d] = 0; etail[d] = 0; gapchk[d] = 1'b0;
            for (int m = 0; m < 2; m++) begin
                mv[d][m] = 1'b0; ma[d][m] = 32'd0; mw[d][m] = 32'd0; ms[d][m] = 4'd0;
                lastrd[d][m] = 32'd0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            chead[k] = 0; ctail[k] = 0; vcnt[k] = 0; done[k] = 1'b0;
        end

        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_s_valid", d, {31'd0, sv[d]}, 32'd0);
            check("rst_ready", d, {30'd0, mr[d][1], mr[d][0]}, 32'd0);
            check("rst_grant", d, {31'd0, gr[d]}, 32'd0);
            check("rst_busy", d, {31'd0, bz[d]}, 32'd0);
`ifdef ARB_TIMEOUT_EN
            check("rst_timeout_err", d, {31'd0, toerr[d]}, 32'd0);
`endif
        end
        rst = 1'b0;
        @(negedge clk);

        // Round-robin with both masters continuously writing: 0,1,0,1,0,1.
        lat[0] = 1;
        for (int i = 0; i < 3; i++) begin
            req(0, 0, 32'h1000 + 32'(i*4), 32'hA000_0000 + 32'(i), 4'hF, 0);
            req(0, 1, 32'h2000 + 32'(i*4), 32'hB000_0000 + 32'(i), 4'hF, 0);
        end
        for (int i = 0; i < 3; i++) begin
            expect_done(0, 1'b0, 32'h1000 + 32'(i*4), 32'hA000_0000 + 32'(i), 4'hF, 1,
                        32'h1000 + 32'(i*4) + RD_OFS);
            expect_done(0, 1'b1, 32'h2000 + 32'(i*4), 32'hB000_0000 + 32'(i), 4'hF, 1,
                        32'h2000 + 32'(i*4) + RD_OFS);
        end
        drain(0, 200);

        // Master 0 read, slave answers two cycles after s_valid.
        lat[0] = 2;
        xfer(0, 0, 32'h0000_0100, 32'd0, 4'h0, 2, 32'h1234_5678);
        drain(0, 100);

        // Master 1 partial write.
        lat[0] = 1;
        xfer(0, 1, 32'h4000_0000, 32'hAABB_CCDD, 4'b0011, 1, 32'h5234_5578);
        drain(0, 100);

        // Master 0 abandons its request mid-BUSY: no ready, last_grant stays at 1.
        lat[0] = 10;
        req(0, 0, 32'h0000_0300, 32'd0, 4'h0, 2);
        drain(0, 100);
        check("abort_busy", 0, {31'd0, bz[0]}, 32'd0);
        check("abort_s_valid", 0, {31'd0, sv[0]}, 32'd0);
        lat[0] = 1;
        xfer(0, 0, 32'h0000_0500, 32'd0, 4'h0, 1, 32'h0000_0500 + RD_OFS);
        xfer(0, 1, 32'h0000_0600, 32'h1122_3344, 4'hF, 1, 32'h0000_0600 + RD_OFS);
        drain(0, 100);

        // Reset hits in the second BUSY cycle of a master 1 transfer.
        lat[0] = 6;
        req(0, 1, 32'h0000_0700, 32'h0, 4'h0, 0);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (sv[0]) found = 1;
        end
        check("reset_test_start", 0, found, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_s_valid", 0, {31'd0, sv[0]}, 32'd0);
        check("async_rst_busy", 0, {31'd0, bz[0]}, 32'd0);
        check("async_rst_ready", 0, {30'd0, mr[0][1], mr[0][0]}, 32'd0);
        check("async_rst_grant", 0, {31'd0, gr[0]}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            chead[k] = ctail[k]; vcnt[k] = 0; done[k] = 1'b0;
        end
        for (int d = 0; d < 2; d++) begin
            ehead[d] = etail[d]; gapchk[d] = 1'b0;
            lastrd[d][0] = 32'd0; lastrd[d][1] = 32'd0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        lat[0] = 1;
        xfer(0, 1, 32'h0000_0800, 32'h55AA_55AA, 4'hF, 1, 32'h0000_0800 + RD_OFS);
        drain(0, 100);

        // Fixed priority: master 0 takes all four, then master 1.
        lat[1] = 1;
        for (int i = 0; i < 4; i++) req(1, 0, 32'h3000 + 32'(i*4), 32'hC0 + 32'(i), 4'hF, 0);
        req(1, 1, 32'h0000_4000, 32'd0, 4'h0, 0);
        for (int i = 0; i < 4; i++)
            expect_done(1, 1'b0, 32'h3000 + 32'(i*4), 32'hC0 + 32'(i), 4'hF, 1, 32'h3000 + 32'(i*4) + RD_OFS);
        expect_done(1, 1'b1, 32'h0000_4000, 32'd0, 4'h0, 1, 32'h0000_4000 + RD_OFS);
        drain(1, 200);

`ifdef ARB_TIMEOUT_EN
        // Silent slave: completion forced on BUSY cycle 8 with the timeout data.
        snever[0] = 1'b1;
        xfer(0, 0, 32'h0000_0900, 32'd0, 4'h0, TO_CYC - 1, 32'hDEAD_BEEF);
        drain(0, 100);
        check("timeout_err_set", 0, {31'd0, toerr[0]}, 32'd1);
        snever[0] = 1'b0;
        lat[0] = 1;
        xfer(0, 1, 32'h0000_0A00, 32'h1, 4'hF, 1, 32'h0000_0A00 + RD_OFS);
        drain(0, 100);
        check("timeout_err_sticky", 0, {31'd0, toerr[0]}, 32'd1);
        // A real answer on the terminal cycle wins over the watchdog.
        lat[1] = TO_CYC - 1;
        xfer(1, 0, 32'h0000_0B00, 32'd0, 4'h0, TO_CYC - 1, 32'h0000_0B00 + RD_OFS);
        drain(1, 100);
        check("timeout_err_terminal", 1, {31'd0, toerr[1]}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", chk, errs);
        $finish;
    end

endmodule
